// File: rtl/conv_pkg.sv
// conv_pkg: activation modes and requantisation helpers shared by the requant blocks
package conv_pkg;
  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_RELU = 2'd1,
    ACT_CLIP = 2'd2
  } act_mode_e;

  // Half-LSB offset added before dropping frac fractional bits (round half up)
  function automatic logic signed [63:0] rnd_ofs(input int frac);
    return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
  endfunction

  // Largest value representable in a w-bit two's complement word
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/requant_coef_tbl.sv
// requant_coef_tbl: per-channel bias/scale register file, one write port, one combinational read port
module requant_coef_tbl
  import conv_pkg::*;
#(
  parameter int NUM_CH      = 16,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [CH_W-1:0]        waddr,
  input  logic [BIAS_WIDTH-1:0]  wbias,
  input  logic [SCALE_WIDTH-1:0] wscale,
  input  logic [CH_W-1:0]        raddr,
  output logic [BIAS_WIDTH-1:0]  rbias,
  output logic [SCALE_WIDTH-1:0] rscale
);
  logic [BIAS_WIDTH-1:0]  bias_mem  [NUM_CH];
  logic [SCALE_WIDTH-1:0] scale_mem [NUM_CH];

  // Table storage; a write lands at the edge, so a same-cycle read still sees the old entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bias_mem[i]  <= '0;
        scale_mem[i] <= '0;
      end
    end else if (we) begin
      bias_mem[waddr]  <= wbias;
      scale_mem[waddr] <= wscale;
    end

  assign rbias  = bias_mem[raddr];
  assign rscale = scale_mem[raddr];
endmodule

// File: rtl/bias_scale_act_pipe.sv
// bias_scale_act_pipe: per-channel bias add, Q-format scale, round, activation and saturation
module bias_scale_act_pipe
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int FRAC_BITS   = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int NUM_CH      = 16,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ch_clr,
  input  logic [CH_W:0]               cfg_num_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [OUT_WIDTH-1:0]        cfg_clip,
  input  logic                        cfg_we,
  input  logic [CH_W-1:0]             cfg_addr,
  input  logic [BIAS_WIDTH-1:0]       cfg_bias,
  input  logic [SCALE_WIDTH-1:0]      cfg_scale,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic [CH_W-1:0]             ch_out,
  output logic                        last_out
);
  localparam int PW = DATA_WIDTH + 1 + SCALE_WIDTH;
  localparam logic signed [PW-1:0] RND  = PW'(rnd_ofs(FRAC_BITS));
  localparam logic signed [PW-1:0] MAXV = PW'(sat_max(OUT_WIDTH));
  localparam logic signed [PW-1:0] MINV = PW'(sat_min(OUT_WIDTH));
  localparam logic [CH_W:0]        ONE  = 1;
  localparam logic [CH_W-1:0]      CH1  = 1;

  logic                          en0, en1, en2, en3, acc;
  logic                          v0, v1, v2;
  logic [CH_W-1:0]               ch_q, ch_cur, ch_nxt;
  logic                          last_cur;
  logic [BIAS_WIDTH-1:0]         tbl_bias;
  logic [SCALE_WIDTH-1:0]        tbl_scale;
  logic [DATA_WIDTH-1:0]         d0;
  logic [BIAS_WIDTH-1:0]         b0;
  logic signed [SCALE_WIDTH-1:0] k0, k1;
  logic [CH_W-1:0]               c0, c1, c2;
  logic                          l0, l1, l2;
  logic signed [DATA_WIDTH:0]    sum1;
  logic signed [PW-1:0]          prod2, r, hi, lo, clip_v, res;

  // A stage may load when it is empty or its content moves on this edge
  assign en3       = !valid_out || ready_in;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign en0       = !v0 || en1;
  assign ready_out = en0;
  assign acc       = valid_in && en0;

  // ch_clr on an accept cycle makes this sample channel 0; out-of-range counts wrap on the next accept
  assign ch_cur   = ch_clr ? '0 : ch_q;
  assign last_cur = {1'b0, ch_cur} == cfg_num_ch - ONE;
  assign ch_nxt   = ({1'b0, ch_cur} >= cfg_num_ch - ONE) ? '0 : ch_cur + CH1;

  requant_coef_tbl #(
    .NUM_CH     (NUM_CH),
    .BIAS_WIDTH (BIAS_WIDTH),
    .SCALE_WIDTH(SCALE_WIDTH)
  ) u_tbl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wbias (cfg_bias),
    .wscale(cfg_scale),
    .raddr (ch_cur),
    .rbias (tbl_bias),
    .rscale(tbl_scale)
  );

  // Channel counter steps only on an accepted sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ch_q <= '0;
    else if (acc) ch_q <= ch_nxt;
    else if (ch_clr) ch_q <= '0;

  // S0: capture the sample with its channel coefficients
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0 <= 1'b0;
      d0 <= '0;
      b0 <= '0;
      k0 <= '0;
      c0 <= '0;
      l0 <= 1'b0;
    end else if (en0) begin
      v0 <= valid_in;
      if (valid_in) begin
        d0 <= data_in;
        b0 <= tbl_bias;
        k0 <= tbl_scale;
        c0 <= ch_cur;
        l0 <= last_cur;
      end
    end

  // S1: bias add one bit wider than the data so it cannot overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1   <= 1'b0;
      sum1 <= '0;
      k1   <= '0;
      c1   <= '0;
      l1   <= 1'b0;
    end else if (en1) begin
      v1 <= v0;
      if (v0) begin
        sum1 <= {d0[DATA_WIDTH-1], d0} + {{(DATA_WIDTH + 1 - BIAS_WIDTH){b0[BIAS_WIDTH-1]}}, b0};
        k1   <= k0;
        c1   <= c0;
        l1   <= l0;
      end
    end

  // S2: full-precision signed multiply by the Q-format scale
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2    <= 1'b0;
      prod2 <= '0;
      c2    <= '0;
      l2    <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        prod2 <= PW'(sum1) * PW'(k1);
        c2    <= c1;
        l2    <= l1;
      end
    end

  // Round half up, then clamp to the window chosen by the activation mode
  always_comb begin
    r      = (prod2 + RND) >>> FRAC_BITS;
    clip_v = cfg_clip[OUT_WIDTH-1] ? '0 : PW'(cfg_clip);
    hi     = (cfg_mode == ACT_CLIP) ? clip_v : MAXV;
    lo     = (cfg_mode == ACT_RELU || cfg_mode == ACT_CLIP) ? '0 : MINV;
    res    = (r > hi) ? hi : (r < lo) ? lo : r;
  end

  // S3: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      ch_out    <= '0;
      last_out  <= 1'b0;
    end else if (en3) begin
      valid_out <= v2;
      if (v2) begin
        data_out <= res[OUT_WIDTH-1:0];
        ch_out   <= c2;
        last_out <= l2;
      end
    end
endmodule
